// File: rtl/axi_mem_responder.sv
// AXI4 responder backed by a 64-bit word array: INCR bursts, independent read and
// write channels, programmable idle cycles before the first read beat.
module axi_mem_responder #(
  parameter int          MEM_WORDS    = 1024,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [63:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic        s_axi_rlast,
  output logic [1:0]  s_axi_rresp,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic addr_in_range(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off[63:IDX_W+3] == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE_ADDR;
    return off[IDX_W+2:3];
  endfunction

  // Response codes are ordered so that the numerically larger one is the worse one.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [63:0] mem [MEM_WORDS];

  // ---------------- read channel ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  r_state_t r_state_reg, r_state_next;

  logic              arready_reg;
  logic [63:0]       r_addr_reg;
  logic [7:0]        r_len_reg;
  logic [7:0]        r_beat_reg;
  logic              r_bad_reg;
  logic [3:0]        r_lat_reg;
  logic [63:0]       rdata_reg;
  logic [1:0]        rresp_reg;
  logic              rlast_reg;
  logic              ar_hs, r_hs, r_load;
  logic [7:0]        r_load_beat;
  logic [63:0]       r_load_data;
  logic [1:0]        r_load_resp;

  assign ar_hs       = s_axi_arvalid && arready_reg && (r_state_reg == R_IDLE);
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  assign r_load      = ((r_state_reg == R_WAIT) && (r_lat_reg == 4'd0)) || (r_hs && !rlast_reg);
  assign r_load_beat = (r_state_reg == R_WAIT) ? 8'd0 : r_beat_reg + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state_reg <= R_IDLE;
    else        r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_WAIT;
      R_WAIT:  if (r_lat_reg == 4'd0) r_state_next = R_DATA;
      R_DATA:  if (r_hs && rlast_reg) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_rvalid = (r_state_reg == R_DATA);
  end

  // r_addr_reg always points at the beat that will be loaded next.
  always_comb begin
    r_load_data = 64'd0;
    r_load_resp = RESP_OKAY;
    if (!addr_in_range(r_addr_reg))
      r_load_resp = RESP_DECERR;
    else if (r_bad_reg)
      r_load_resp = RESP_SLVERR;
    else
      r_load_data = mem[addr_index(r_addr_reg)];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arready_reg <= 1'b0;
      r_addr_reg  <= 64'd0;
      r_len_reg   <= 8'd0;
      r_beat_reg  <= 8'd0;
      r_bad_reg   <= 1'b0;
      r_lat_reg   <= 4'd0;
      rdata_reg   <= 64'd0;
      rresp_reg   <= RESP_OKAY;
      rlast_reg   <= 1'b0;
    end else begin
      arready_reg <= (r_state_next == R_IDLE);
      if (ar_hs) begin
        r_addr_reg <= s_axi_araddr;
        r_len_reg  <= s_axi_arlen;
        r_bad_reg  <= (s_axi_arsize != 3'b011) || (s_axi_arburst != 2'b01);
        r_lat_reg  <= 4'(READ_LATENCY);
      end else if ((r_state_reg == R_WAIT) && (r_lat_reg != 4'd0)) begin
        r_lat_reg <= r_lat_reg - 4'd1;
      end
      if (r_load) begin
        rdata_reg  <= r_load_data;
        rresp_reg  <= r_load_resp;
        rlast_reg  <= (r_load_beat == r_len_reg);
        r_beat_reg <= r_load_beat;
        r_addr_reg <= r_addr_reg + 64'd8;
      end
    end
  end

  assign s_axi_arready = arready_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = rresp_reg;
  assign s_axi_rlast   = rlast_reg;

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state_reg, w_state_next;

  logic        awready_reg;
  logic [63:0] w_addr_reg;
  logic [7:0]  w_len_reg;
  logic [7:0]  w_beat_reg;
  logic        w_bad_reg;
  logic [1:0]  w_err_reg;
  logic [1:0]  w_err_next;
  logic [1:0]  bresp_reg;
  logic        aw_hs, w_hs, b_hs, w_final, w_in_range, mem_we;

  assign aw_hs      = s_axi_awvalid && awready_reg && (w_state_reg == W_IDLE);
  assign w_hs       = s_axi_wvalid && (w_state_reg == W_DATA);
  assign b_hs       = s_axi_bvalid && s_axi_bready;
  assign w_final    = (w_beat_reg == w_len_reg);
  assign w_in_range = addr_in_range(w_addr_reg);
  assign mem_we     = w_hs && !w_bad_reg && w_in_range;

  // wlast disagreeing with the beat count in either direction is a protocol error.
  always_comb begin
    w_err_next = w_err_reg;
    if (!w_in_range)            w_err_next = worst(w_err_next, RESP_DECERR);
    if (s_axi_wlast != w_final) w_err_next = worst(w_err_next, RESP_SLVERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) w_state_reg <= W_IDLE;
    else        w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (aw_hs) w_state_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_state_next = W_RESP;
      W_RESP:  if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_wready = (w_state_reg == W_DATA);
    s_axi_bvalid = (w_state_reg == W_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      awready_reg <= 1'b0;
      w_addr_reg  <= 64'd0;
      w_len_reg   <= 8'd0;
      w_beat_reg  <= 8'd0;
      w_bad_reg   <= 1'b0;
      w_err_reg   <= RESP_OKAY;
      bresp_reg   <= RESP_OKAY;
    end else begin
      awready_reg <= (w_state_next == W_IDLE);
      if (aw_hs) begin
        w_addr_reg <= s_axi_awaddr;
        w_len_reg  <= s_axi_awlen;
        w_beat_reg <= 8'd0;
        w_bad_reg  <= (s_axi_awsize != 3'b011) || (s_axi_awburst != 2'b01);
        w_err_reg  <= ((s_axi_awsize != 3'b011) || (s_axi_awburst != 2'b01)) ? RESP_SLVERR : RESP_OKAY;
      end else if (w_hs) begin
        w_err_reg  <= w_err_next;
        w_addr_reg <= w_addr_reg + 64'd8;
        w_beat_reg <= w_beat_reg + 8'd1;
        if (w_final) bresp_reg <= w_err_next;
      end
    end
  end

  // Array has no reset so it maps onto block RAM; a same-edge read load sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) mem[addr_index(w_addr_reg)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi_awready = awready_reg;
  assign s_axi_bresp   = bresp_reg;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed + randomized bench for axi_mem_responder against a word-array reference model.
module tb_axi_mem_responder;

  localparam int          MEM_WORDS    = 1024;
  localparam logic [63:0] BASE_ADDR    = 64'h0;
  localparam int          READ_LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_arvalid, s_axi_arready;
  logic [63:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_rdata;
  logic        s_axi_rlast;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready;
  logic [63:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;

  axi_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] ref_mem [MEM_WORDS];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic bit in_mem(input logic [63:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) / 64'd8) < 64'(MEM_WORDS));
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a - BASE_ADDR) / 64'd8);
  endfunction

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Burst of len+1 beats from wbuf/sbuf; wlast is driven only on beat wlast_at.
  task automatic axi_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int wlast_at);
    bit          illegal;
    logic [1:0]  exp_resp;
    logic [63:0] a;
    int          to;
    illegal  = (size != 3'b011) || (burst != 2'b01);
    exp_resp = illegal ? 2'b10 : 2'b00;
    for (int b = 0; b <= len; b++) begin
      a = addr + 64'(b) * 64'd8;
      if (!in_mem(a)) exp_resp = max2(exp_resp, 2'b11);
      else if (!illegal)
        for (int k = 0; k < 8; k++)
          if (sbuf[b][k]) ref_mem[word_of(a)][k*8 +: 8] = wbuf[b][k*8 +: 8];
      if ((b == wlast_at) != (b == len)) exp_resp = max2(exp_resp, 2'b10);
    end
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    to = 0;
    while (!s_axi_awready && to < 100) begin tick(); to++; end
    if (!s_axi_awready) check("aw_timeout", 64'(s_axi_awready), 64'd1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[b]; s_axi_wstrb = sbuf[b];
      s_axi_wlast = (b == wlast_at);
      to = 0;
      while (!s_axi_wready && to < 100) begin tick(); to++; end
      if (!s_axi_wready) check("w_timeout", 64'(s_axi_wready), 64'd1);
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1;
    to = 0;
    while (!s_axi_bvalid && to < 100) begin tick(); to++; end
    check("bvalid", 64'(s_axi_bvalid), 64'd1);
    check("bresp", 64'(s_axi_bresp), 64'(exp_resp));
    tick();
    s_axi_bready = 1'b0;
    check("bvalid_clear", 64'(s_axi_bvalid), 64'd0);
    $display("WRITE addr=%h len=%0d size=%0d burst=%0d bresp=%0d", addr, len, size, burst, s_axi_bresp);
  endtask

  // rmode 0: rready always 1; 1: random; 2: rpat bits LSB-first per data cycle, then 1.
  task automatic axi_read(input logic [63:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int rmode, input logic [15:0] rpat);
    bit          illegal;
    logic [63:0] a, exp_data;
    logic [1:0]  exp_resp;
    int          to, lat, beat, cyc;
    bit          rr;
    illegal = (size != 3'b011) || (burst != 2'b01);
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    to = 0;
    while (!s_axi_arready && to < 100) begin tick(); to++; end
    if (!s_axi_arready) check("ar_timeout", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 1'b0;
    lat = 0;
    while (!s_axi_rvalid && lat < 40) begin tick(); lat++; end
    check("r_latency", 64'(lat), 64'(READ_LATENCY + 1));
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 2000) begin
      a = addr + 64'(beat) * 64'd8;
      if (!in_mem(a))   begin exp_resp = 2'b11; exp_data = 64'd0; end
      else if (illegal) begin exp_resp = 2'b10; exp_data = 64'd0; end
      else              begin exp_resp = 2'b00; exp_data = ref_mem[word_of(a)]; end
      check("rvalid", 64'(s_axi_rvalid), 64'd1);
      check("rdata", s_axi_rdata, exp_data);
      check("rresp", 64'(s_axi_rresp), 64'(exp_resp));
      check("rlast", 64'(s_axi_rlast), 64'(beat == len));
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = 1'($urandom_range(0, 1));
        default: rr = (cyc < 16) ? rpat[cyc] : 1'b1;
      endcase
      s_axi_rready = rr;
      tick();
      cyc++;
      if (rr) beat++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", 64'(beat), 64'(len + 1));
    check("rvalid_end", 64'(s_axi_rvalid), 64'd0);
    check("arready_end", 64'(s_axi_arready), 64'd1);
    $display("READ  addr=%h len=%0d size=%0d burst=%0d latency=%0d cycles=%0d", addr, len, size, burst, lat, cyc);
  endtask

  initial begin
    logic [63:0] ra;
    int          rl, to;
    reset = 1'b0;
    s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 3'b011; s_axi_arburst = 2'b01;
    s_axi_rready = 0;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 3'b011; s_axi_awburst = 2'b01;
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_bready = 0;
    repeat (3) tick();
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_rlast", 64'(s_axi_rlast), 64'd0);
    reset = 1'b1;
    #1;
    check("rel_arready_pre", 64'(s_axi_arready), 64'd0);
    check("rel_awready_pre", 64'(s_axi_awready), 64'd0);
    tick();
    check("rel_arready", 64'(s_axi_arready), 64'd1);
    check("rel_awready", 64'(s_axi_awready), 64'd1);
    check("idle_wready", 64'(s_axi_wready), 64'd0);

    // Fill the whole array so every later read has a defined expected value.
    for (int blk = 0; blk < MEM_WORDS / 256; blk++) begin
      for (int b = 0; b < 256; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
      axi_write(BASE_ADDR + 64'(blk) * 64'd2048, 255, 3'b011, 2'b01, 255);
    end

    for (int b = 0; b < 4; b++) begin wbuf[b] = 64'(b + 1); sbuf[b] = 8'hFF; end
    axi_write(64'h40, 3, 3'b011, 2'b01, 3);
    axi_read(64'h40, 3, 3'b011, 2'b01, 0, 16'h0);

    wbuf[0] = 64'h0; sbuf[0] = 8'hFF;
    axi_write(64'h80, 0, 3'b011, 2'b01, 0);
    wbuf[0] = 64'hAAAA_BBBB_CCCC_DDDD; sbuf[0] = 8'h0F;
    axi_write(64'h80, 0, 3'b011, 2'b01, 0);
    axi_read(64'h80, 0, 3'b011, 2'b01, 0, 16'h0);
    check("strobe_model", ref_mem[16], 64'h0000_0000_CCCC_DDDD);

    axi_read(64'h40, 1, 3'b011, 2'b01, 2, 16'b1001);

    axi_read(BASE_ADDR + 64'(MEM_WORDS) * 64'd8, 1, 3'b011, 2'b01, 0, 16'h0);
    wbuf[0] = 64'hDEAD_BEEF_0000_1111; sbuf[0] = 8'hFF;
    axi_write(64'h80, 0, 3'b010, 2'b01, 0);
    axi_read(64'h80, 0, 3'b011, 2'b01, 0, 16'h0);
    axi_read(64'h40, 1, 3'b011, 2'b10, 0, 16'h0);

    for (int b = 0; b < 3; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
    axi_write(64'h200, 2, 3'b011, 2'b01, 1);
    axi_read(64'h200, 2, 3'b011, 2'b01, 1, 16'h0);

    // Reset in the middle of a stalled read burst.
    s_axi_araddr = 64'h100; s_axi_arlen = 8'd15; s_axi_arsize = 3'b011; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    to = 0;
    while (!s_axi_rvalid && to < 40) begin tick(); to++; end
    check("pre_reset_rvalid", 64'(s_axi_rvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("midrst_arready", 64'(s_axi_arready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrel_arready_pre", 64'(s_axi_arready), 64'd0);
    tick();
    check("midrel_arready", 64'(s_axi_arready), 64'd1);
    axi_read(64'h100, 3, 3'b011, 2'b01, 0, 16'h0);

    // Concurrent write and read to disjoint regions.
    for (int b = 0; b < 8; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'($urandom); end
    fork
      axi_write(64'h1000, 7, 3'b011, 2'b01, 7);
      axi_read(64'h300, 7, 3'b011, 2'b01, 1, 16'h0);
    join
    axi_read(64'h1000, 7, 3'b011, 2'b01, 0, 16'h0);

    for (int it = 0; it < 16; it++) begin
      rl = int'($urandom_range(0, 7));
      ra = BASE_ADDR + 64'($urandom_range(0, MEM_WORDS + 4)) * 64'd8 + 64'($urandom_range(0, 7));
      for (int b = 0; b <= rl; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'($urandom); end
      axi_write(ra, rl, 3'b011, 2'b01, rl);
      axi_read(ra, rl, 3'b011, 2'b01, 1, 16'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
